// File: rtl/mem_arbiter_if.sv
// Memory-side bundle between the two caches, the arbiter and the RAM model.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the caches' requests and models the RAM.
interface mem_arbiter_if;
   // instruction cache side
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   // data cache side
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;
   // RAM side
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;
   // status
   logic [7:0]  err_count;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
             err_count
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
             err_count
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between a read-only instruction cache and a
// read/write data cache. Data requests have priority, but after STARVE_LIMIT
// consecutive data grants completed while an instruction fetch was waiting,
// the instruction side wins the next arbitration. A grant is held until the
// RAM reports ACCESS; ERROR responses are retried and counted.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input logic          CLK,
   input logic          nRST,
   mem_arbiter_if.slave bus
);

   localparam logic [1:0] RAM_FREE   = 2'd0;
   localparam logic [1:0] RAM_BUSY   = 2'd1;
   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IGRANT = 2'd1,
      DGRANT = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] starve_q, starve_d;
   logic [7:0] err_q, err_d;

   // Error counter sticks at its maximum instead of wrapping.
   function automatic logic [7:0] err_sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Starvation count never exceeds the configured limit.
   function automatic logic [3:0] starve_sat_inc(input logic [3:0] v);
      return (v >= STARVE_MAX) ? STARVE_MAX : v + 4'd1;
   endfunction

   // Read data is a straight passthrough; each cache only samples it on its
   // own wait-low cycle.
   assign bus.iload     = bus.ramload;
   assign bus.dload     = bus.ramload;
   assign bus.err_count = err_q;

   // State, starvation count and error count registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         starve_q <= 4'd0;
         err_q    <= 8'd0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         err_q    <= err_d;
      end
   end

   // Arbitration, grant tracking and RAM-side output decode.
   always_comb begin
      state_d      = state_q;
      starve_d     = starve_q;
      err_d        = err_q;
      bus.iwait    = 1'b1;
      bus.dwait    = 1'b1;
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = 32'd0;
      bus.ramstore = 32'd0;

      unique case (state_q)
         IDLE: begin
            // Instruction side only overrides data once it has been passed
            // over STARVE_LIMIT times in a row.
            if ((bus.dREN || bus.dWEN) &&
                !(bus.iREN && (starve_q == STARVE_MAX))) begin
               state_d = DGRANT;
            end else if (bus.iREN) begin
               state_d = IGRANT;
            end
         end

         IGRANT: begin
            if (!bus.iREN) begin
               // Requester withdrew: abandon silently, nothing completes.
               state_d = IDLE;
            end else begin
               bus.ramREN  = 1'b1;
               bus.ramaddr = bus.iaddr;
               case (bus.ramstate)
                  RAM_ACCESS: begin
                     bus.iwait = 1'b0;
                     state_d   = IDLE;
                     starve_d  = 4'd0;
                  end
                  RAM_ERROR: err_d = err_sat_inc(err_q);
                  RAM_BUSY,
                  RAM_FREE:  ;
                  default:   ;
               endcase
            end
         end

         DGRANT: begin
            if (!(bus.dREN || bus.dWEN)) begin
               state_d = IDLE;
            end else begin
               // Direction follows the live request; a write wins over a read.
               bus.ramWEN   = bus.dWEN;
               bus.ramREN   = bus.dREN & ~bus.dWEN;
               bus.ramaddr  = bus.daddr;
               bus.ramstore = bus.dstore;
               case (bus.ramstate)
                  RAM_ACCESS: begin
                     bus.dwait = 1'b0;
                     state_d   = IDLE;
                     starve_d  = bus.iREN ? starve_sat_inc(starve_q) : 4'd0;
                  end
                  RAM_ERROR: err_d = err_sat_inc(err_q);
                  RAM_BUSY,
                  RAM_FREE:  ;
                  default:   ;
               endcase
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of per-cycle vectors covering the
// basic transfers, plus hand-written reset, starvation and saturation runs.
module tb_mem_arbiter;

   localparam logic [1:0] FR = 2'd0;
   localparam logic [1:0] BS = 2'd1;
   localparam logic [1:0] AC = 2'd2;
   localparam logic [1:0] ER = 2'd3;

   logic CLK;
   logic nRST;

   mem_arbiter_if bus ();

   mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        iren;
      logic [31:0] iaddr;
      logic        dren;
      logic        dwen;
      logic [31:0] daddr;
      logic [31:0] dstore;
      logic [31:0] rload;
      logic [1:0]  rs;
      logic        e_iw;
      logic        e_dw;
      logic        e_ren;
      logic        e_wen;
      logic [31:0] e_addr;
      logic [31:0] e_store;
      logic [7:0]  e_err;
   } vec_t;

   vec_t tbl [22];

   function automatic vec_t mk(
      input logic iren, input logic [31:0] iaddr,
      input logic dren, input logic dwen, input logic [31:0] daddr,
      input logic [31:0] dstore, input logic [31:0] rload, input logic [1:0] rs,
      input logic e_iw, input logic e_dw, input logic e_ren, input logic e_wen,
      input logic [31:0] e_addr, input logic [31:0] e_store, input logic [7:0] e_err);
      vec_t v;
      v.iren = iren;  v.iaddr = iaddr; v.dren = dren; v.dwen = dwen;
      v.daddr = daddr; v.dstore = dstore; v.rload = rload; v.rs = rs;
      v.e_iw = e_iw; v.e_dw = e_dw; v.e_ren = e_ren; v.e_wen = e_wen;
      v.e_addr = e_addr; v.e_store = e_store; v.e_err = e_err;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic iren, input logic [31:0] iaddr, input logic dren,
                        input logic dwen, input logic [31:0] daddr,
                        input logic [31:0] dstore, input logic [31:0] rload,
                        input logic [1:0] rs);
      bus.iREN = iren; bus.iaddr = iaddr; bus.dREN = dren; bus.dWEN = dwen;
      bus.daddr = daddr; bus.dstore = dstore; bus.ramload = rload;
      bus.ramstate = rs;
   endtask

   task automatic chk_idle(input string nm, input logic [7:0] e_err);
      chk({nm, "_iwait"},  32'(bus.iwait),  32'd1);
      chk({nm, "_dwait"},  32'(bus.dwait),  32'd1);
      chk({nm, "_ramREN"}, 32'(bus.ramREN), 32'd0);
      chk({nm, "_ramWEN"}, 32'(bus.ramWEN), 32'd0);
      chk({nm, "_ramaddr"}, bus.ramaddr,    32'd0);
      chk({nm, "_ramstore"}, bus.ramstore,  32'd0);
      chk({nm, "_err"}, 32'(bus.err_count), 32'(e_err));
   endtask

   byte exp_g [10];
   byte got_g [10];

   initial begin
      // single read, then write with three BUSY cycles
      tbl[0]  = mk(1, 32'h40, 0, 0, 0, 0, 0, FR,            1, 1, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 32'h40, 0, 0, 0, 0, 32'hDEADBEEF, AC, 0, 1, 1, 0, 32'h40, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, FR,                 1, 1, 0, 0, 0, 0, 0);
      tbl[3]  = mk(0, 0, 0, 1, 32'h80, 32'h1234, 0, FR,     1, 1, 0, 0, 0, 0, 0);
      tbl[4]  = mk(0, 0, 0, 1, 32'h80, 32'h1234, 0, BS,     1, 1, 0, 1, 32'h80, 32'h1234, 0);
      tbl[5]  = mk(0, 0, 0, 1, 32'h80, 32'h1234, 0, BS,     1, 1, 0, 1, 32'h80, 32'h1234, 0);
      tbl[6]  = mk(0, 0, 0, 1, 32'h80, 32'h1234, 0, BS,     1, 1, 0, 1, 32'h80, 32'h1234, 0);
      tbl[7]  = mk(0, 0, 0, 1, 32'h80, 32'h1234, 0, AC,     1, 0, 0, 1, 32'h80, 32'h1234, 0);
      tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, FR,                 1, 1, 0, 0, 0, 0, 0);
      // data read retried through two ERROR responses
      tbl[9]  = mk(0, 0, 1, 0, 32'hC0, 0, 0, FR,            1, 1, 0, 0, 0, 0, 0);
      tbl[10] = mk(0, 0, 1, 0, 32'hC0, 0, 0, ER,            1, 1, 1, 0, 32'hC0, 0, 0);
      tbl[11] = mk(0, 0, 1, 0, 32'hC0, 0, 0, ER,            1, 1, 1, 0, 32'hC0, 0, 1);
      tbl[12] = mk(0, 0, 1, 0, 32'hC0, 0, 32'h55AA, AC,     1, 0, 1, 0, 32'hC0, 0, 2);
      tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, FR,                 1, 1, 0, 0, 0, 0, 2);
      // instruction fetch aborted on its second grant cycle
      tbl[14] = mk(1, 32'h44, 0, 0, 0, 0, 0, FR,            1, 1, 0, 0, 0, 0, 2);
      tbl[15] = mk(1, 32'h44, 0, 0, 0, 0, 0, BS,            1, 1, 1, 0, 32'h44, 0, 2);
      tbl[16] = mk(0, 32'h44, 0, 0, 0, 0, 0, BS,            1, 1, 0, 0, 0, 0, 2);
      tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, FR,                 1, 1, 0, 0, 0, 0, 2);
      // simultaneous requests: data wins, write beats read within a grant
      tbl[18] = mk(1, 32'h8, 1, 0, 32'h10, 0, 0, FR,        1, 1, 0, 0, 0, 0, 2);
      tbl[19] = mk(1, 32'h8, 1, 0, 32'h10, 0, 0, AC,        1, 0, 1, 0, 32'h10, 0, 2);
      tbl[20] = mk(1, 32'h8, 1, 0, 32'h10, 0, 0, FR,        1, 1, 0, 0, 0, 0, 2);
      tbl[21] = mk(1, 32'h8, 1, 1, 32'h10, 32'h77, 0, AC,   1, 0, 0, 1, 32'h10, 32'h77, 2);

      exp_g = '{"D", "D", "D", "D", "I", "D", "D", "D", "D", "I"};

      // reset held with both requests asserted
      nRST = 1'b0;
      drive(1, 32'h20, 1, 0, 32'h10, 0, 0, FR);
      step();
      step();
      #3;
      chk_idle("rst_hold", 8'd0);
      step();
      nRST = 1'b1;
      #3;
      chk("rel_idle_ramREN", 32'(bus.ramREN), 32'd0);
      chk("rel_idle_dwait",  32'(bus.dwait),  32'd1);
      step();
      bus.ramstate = BS;
      #3;
      chk("rel_grant_ramREN", 32'(bus.ramREN), 32'd1);
      chk("rel_grant_addr",   bus.ramaddr,     32'h10);
      // asynchronous reset in the middle of the data grant
      nRST = 1'b0;
      #1;
      chk_idle("mid_rst", 8'd0);
      drive(0, 0, 0, 0, 0, 0, 0, FR);
      step();
      step();
      nRST = 1'b1;

      for (int r = 0; r < 22; r++) begin
         drive(tbl[r].iren, tbl[r].iaddr, tbl[r].dren, tbl[r].dwen,
               tbl[r].daddr, tbl[r].dstore, tbl[r].rload, tbl[r].rs);
         #3;
         chk($sformatf("row%0d_iwait", r),  32'(bus.iwait),  32'(tbl[r].e_iw));
         chk($sformatf("row%0d_dwait", r),  32'(bus.dwait),  32'(tbl[r].e_dw));
         chk($sformatf("row%0d_ramREN", r), 32'(bus.ramREN), 32'(tbl[r].e_ren));
         chk($sformatf("row%0d_ramWEN", r), 32'(bus.ramWEN), 32'(tbl[r].e_wen));
         chk($sformatf("row%0d_ramaddr", r), bus.ramaddr,    tbl[r].e_addr);
         chk($sformatf("row%0d_ramstore", r), bus.ramstore,  tbl[r].e_store);
         chk($sformatf("row%0d_err", r), 32'(bus.err_count), 32'(tbl[r].e_err));
         chk($sformatf("row%0d_iload", r), bus.iload, tbl[r].rload);
         chk($sformatf("row%0d_dload", r), bus.dload, tbl[r].rload);
         step();
      end

      // starvation: both sides request continuously, zero-wait RAM
      drive(0, 0, 0, 0, 0, 0, 0, FR);
      nRST = 1'b0;
      step();
      nRST = 1'b1;
      drive(1, 32'h100, 1, 0, 32'h200, 0, 0, AC);
      begin
         int ng;
         int cyc;
         ng  = 0;
         cyc = 0;
         while (cyc < 40 && ng < 10) begin
            #3;
            if (!bus.iwait && !bus.dwait) begin
               total++;
               bad++;
               $display("FAIL starve_both_wait_low: cycle %0d", cyc);
            end
            if (!bus.iwait) begin
               got_g[ng] = "I";
               ng++;
            end else if (!bus.dwait) begin
               got_g[ng] = "D";
               ng++;
            end
            cyc++;
            step();
         end
         chk("starve_grant_count", 32'(ng), 32'd10);
         chk("starve_cycles", 32'(cyc), 32'd20);
         for (int g = 0; g < ng; g++)
            chk($sformatf("starve_grant%0d", g), 32'(got_g[g]), 32'(exp_g[g]));
      end

      // err_count saturation under a long ERROR retry
      drive(0, 0, 0, 0, 0, 0, 0, FR);
      nRST = 1'b0;
      step();
      nRST = 1'b1;
      drive(0, 0, 1, 0, 32'h300, 0, 0, ER);
      step();
      #3;
      chk("sat_start_ramREN", 32'(bus.ramREN), 32'd1);
      chk("sat_start_err", 32'(bus.err_count), 32'd0);
      for (int j = 1; j <= 300; j++) begin
         step();
         if (j == 100) begin
            #3;
            chk("sat_err_100", 32'(bus.err_count), 32'd100);
         end
      end
      #3;
      chk("sat_err_255", 32'(bus.err_count), 32'd255);
      chk("sat_retry_ramREN", 32'(bus.ramREN), 32'd1);
      chk("sat_retry_dwait", 32'(bus.dwait), 32'd1);
      bus.ramstate = AC;
      #1;
      chk("sat_done_dwait", 32'(bus.dwait), 32'd0);
      step();
      bus.dREN = 1'b0;
      #3;
      chk("sat_after_err", 32'(bus.err_count), 32'd255);
      chk("sat_after_dwait", 32'(bus.dwait), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single RAM port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the two caches' memory-side signals and the RAM model.
- Arbitrates with data priority and a starvation limit that guarantees instruction fetch progress.
- Holds each grant until the RAM reports ACCESS, and retries on RAM error.

## Interface
Parameters:
- STARVE_LIMIT, 4, consecutive data grants allowed while an instruction request waits (1..15)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  low for exactly the cycle the icache read completes
- iload  out  32  read data to icache (ramload passthrough)
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request (wins if dREN also high)
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dwait  out  1  low for exactly the cycle the dcache transfer completes
- dload  out  32  read data to dcache (ramload passthrough)
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- err_count  out  8  saturating count of ERROR cycles seen during a grant

## Operation
FSM states: IDLE, IGRANT, DGRANT. Reset state is IDLE.

IDLE:
- No RAM enable is driven.
- Arbitration picks the next state, registered at the next edge:
  - dREN|dWEN high and not (iREN high and starve == STARVE_LIMIT) -> DGRANT.
  - else iREN high -> IGRANT.
  - else stay in IDLE.

IGRANT:
- Drives ramREN=1, ramaddr=iaddr.

DGRANT:
- Drives ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore.
- Direction is re-evaluated each cycle from the live inputs.

In either grant state:
- ramstate==ACCESS: the owner's wait goes low combinationally that cycle; next state IDLE.
- ramstate==BUSY/FREE: hold the grant; wait stays high.
- ramstate==ERROR: hold the grant and keep requesting (retry); err_count increments, saturating at 255.
- Owner drops its request (IGRANT: iREN=0; DGRANT: dREN=dWEN=0): RAM enables deassert that cycle; next state IDLE; no wait-low; no counter update.

Starvation counter `starve` (4 bits, internal):
- On a DGRANT completion with iREN high: starve+1, saturating at STARVE_LIMIT.
- On a DGRANT completion with iREN low: starve=0.
- On any IGRANT completion: starve=0.

Outputs outside a grant:
- iwait=dwait=1, ramREN=ramWEN=0, ramaddr=0, ramstore=0.
- The non-owner's wait is always 1.

iload and dload are always ramload; a requester must only sample on its wait-low cycle.

## Timing
- Reset (async, any time including mid-grant):
  - state=IDLE, starve=0, err_count=0.
  - iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - An interrupted transfer is abandoned; the requester must re-request.
- Minimum latency: request high in cycle 0 (IDLE) -> RAM enable in cycle 1 -> if ramstate==ACCESS in cycle 1, wait low in cycle 1.
- Back-to-back: at least one IDLE cycle between grants; steady-state throughput is one transfer per 2 cycles with a zero-wait RAM.
- Simultaneous iREN and dREN in IDLE with starve<STARVE_LIMIT: data wins.
- Simultaneous iREN and dREN in IDLE with starve==STARVE_LIMIT: instruction wins.
- The grant owner is fixed for the whole grant; a new request from the other side never pre-empts it.
- err_count at 255 plus another ERROR: stays 255.

## Test plan
- Reset: hold nRST=0 with iREN=dREN=1 -> iwait=dwait=1, ramREN=ramWEN=0, err_count=0; release nRST -> IDLE, first grant one cycle later.
- Single read: iREN=1, iaddr=0x40, RAM returns ACCESS with ramload=0xDEADBEEF on the first grant cycle -> ramREN=1 and ramaddr=0x40 in cycle 1; iwait=0 and iload=0xDEADBEEF only in cycle 1; IDLE in cycle 2.
- Write with latency: dWEN=1, daddr=0x80, dstore=0x1234, ramstate BUSY for 3 cycles then ACCESS -> ramWEN held 4 cycles with ramstore=0x1234; dwait low only on the ACCESS cycle.
- Starvation: STARVE_LIMIT=4, iREN and dREN held high continuously, zero-wait RAM -> grant order D,D,D,D,I,D,D,D,D,I; starve returns to 0 after each I.
- Error retry: DGRANT read with ramstate ERROR,ERROR,ACCESS -> ramREN held 3 cycles; err_count=2; dwait low on the third cycle.
- Abort and mid-grant reset:
  - iREN dropped on the second IGRANT cycle -> ramREN=0 that cycle, IDLE next, iwait never low.
  - Separately, nRST pulsed mid-DGRANT -> all outputs return to their reset values immediately.
